tube_host_ctrl: RTL

Host-side controller for the Tube ULA. It sits between the host bus and the four register-channel FIFO pairs (parasite->host and host->parasite).
- Decodes host accesses to the eight Tube addresses.
- Issues one-cycle read and write strobes to the FIFOs.
- Holds the control-flag register.
- Sequences FIFO clear and power-on reset.
- Generates the host and parasite interrupt lines from flags and FIFO levels.

---
 rtl/tube_pkg.sv | 31 +++
 rtl/tube_host_ctrl_if.sv | 11 +
 rtl/tube_clear_seq.sv | 60 ++++++
 rtl/tube_host_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared constants for the Tube host-side controller: flag bit positions,
// channel indices, status-byte layout and the clear-sequencer states.
package tube_pkg;

  localparam int FLAG_Q = 0;
  localparam int FLAG_I = 1;
  localparam int FLAG_J = 2;
  localparam int FLAG_M = 3;
  localparam int FLAG_V = 4;
  localparam int FLAG_P = 5;
  localparam int FLAG_T = 6;

  localparam int CH_R1 = 0;
  localparam int CH_R2 = 1;
  localparam int CH_R3 = 2;
  localparam int CH_R4 = 3;

  localparam int ST_AVAIL   = 7;
  localparam int ST_NOTFULL = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // R3 counts as ready once it holds one byte, or two when V is set.
  function automatic logic r3_ready(input logic [1:0] level, input logic v);
    return v ? (level >= 2'd2) : (level >= 2'd1);
  endfunction

endpackage

// File: rtl/tube_host_ctrl_if.sv
// Host bus side of the Tube: select, direction, address and data.
interface tube_host_ctrl_if;
  logic       h_cs_b;
  logic       h_rdnw;
  logic [2:0] h_addr;
  logic [7:0] h_din;
  logic [7:0] h_dout;

  modport master (output h_cs_b, h_rdnw, h_addr, h_din, input h_dout);
  modport slave  (input h_cs_b, h_rdnw, h_addr, h_din, output h_dout);
endinterface

// File: rtl/tube_clear_seq.sv
// FIFO clear sequencer.
//   state | meaning
//   IDLE  | FIFOs running, fifo_rst low
//   CLEAR | fifo_rst high, counter runs up to RST_CYCLES-1
// done is high in the last CLEAR cycle; completion takes priority over a
// restart arriving in that same cycle.
module tube_clear_seq #(
  parameter int RST_CYCLES = 4
) (
  input  logic h_phi2,
  input  logic h_rst_b,
  input  logic start,
  output logic fifo_rst,
  output logic done
);
  import tube_pkg::*;

  localparam logic [3:0] CNT_LAST = 4'(RST_CYCLES - 1);

  clr_state_e state;
  logic [3:0] cnt;

  assign done = (state == CLEAR) && (cnt == CNT_LAST);

  // State, counter and registered fifo_rst; reset lands in CLEAR.
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state    <= CLEAR;
      cnt      <= '0;
      fifo_rst <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLEAR;
            cnt      <= '0;
            fifo_rst <= 1'b1;
          end
        end
        CLEAR: begin
          if (done) begin
            state    <= IDLE;
            cnt      <= '0;
            fifo_rst <= 1'b0;
          end else if (start) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state    <= CLEAR;
          cnt      <= '0;
          fifo_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/tube_host_ctrl.sv
// Tube ULA host-side controller: address decode, FIFO strobes, control
// flags, clear sequencing and interrupt generation.
module tube_host_ctrl #(
  parameter int RST_CYCLES = 4
) (
  input  logic              h_phi2,
  input  logic              h_rst_b,
  tube_host_ctrl_if.slave   bus,
  input  logic [31:0]       ph_data,
  input  logic [3:0]        ph_avail,
  input  logic [1:0]        ph_r3_level,
  output logic [3:0]        ph_rd,
  output logic [3:0]        hp_wr,
  input  logic [3:0]        hp_full,
  input  logic [3:0]        hp_avail,
  input  logic [1:0]        hp_r3_level,
  output logic              fifo_rst,
  output logic [6:0]        flags,
  output logic              h_irq_b,
  output logic              p_irq_b,
  output logic              p_nmi_b,
  output logic              p_rst_b
);
  import tube_pkg::*;

  logic [6:0] flag_q, flag_nxt;
  logic [1:0] ch;
  logic       acc_rd, acc_wr, is_data, flag_wr, t_start, clr_done;
  logic       ch_avail;
  logic [7:0] dout_c;
  logic       h_irq_q, p_irq_q, p_nmi_q, por_q;
  logic       unused_ok;

  assign unused_ok = ^hp_avail[2:1];

  assign ch      = bus.h_addr[2:1];
  assign is_data = bus.h_addr[0];
  assign acc_rd  = !bus.h_cs_b && bus.h_rdnw;
  assign acc_wr  = !bus.h_cs_b && !bus.h_rdnw;
  assign flag_wr = acc_wr && (bus.h_addr == 3'd0);
  assign t_start = flag_wr && bus.h_din[7] && bus.h_din[FLAG_T];

  tube_clear_seq #(.RST_CYCLES(RST_CYCLES)) u_clear_seq (
    .h_phi2   (h_phi2),
    .h_rst_b  (h_rst_b),
    .start    (t_start),
    .fifo_rst (fifo_rst),
    .done     (clr_done)
  );

  assign ph_rd = (acc_rd && is_data && !fifo_rst) ? (4'b0001 << ch) : 4'b0000;
  assign hp_wr = (acc_wr && is_data && !fifo_rst && !hp_full[ch]) ? (4'b0001 << ch) : 4'b0000;

  assign ch_avail = (ch == 2'(CH_R3)) ? r3_ready(ph_r3_level, flag_q[FLAG_V]) : ph_avail[ch];

  // Read mux: data byte for odd addresses, status byte for even ones.
  always_comb begin
    dout_c = '0;
    if (is_data) begin
      dout_c = ph_data[{ch, 3'b000} +: 8];
    end else begin
      dout_c[ST_AVAIL]   = ch_avail;
      dout_c[ST_NOTFULL] = ~hp_full[ch];
      if (ch == 2'(CH_R1)) dout_c[5:0] = flag_q[5:0];
    end
  end
  assign bus.h_dout = dout_c;

  // Next flag value: host set/clear (T can only be set by the host), then
  // completion of a clear drops T.
  always_comb begin
    flag_nxt = flag_q;
    if (flag_wr) begin
      if (bus.h_din[7]) flag_nxt = flag_q | bus.h_din[6:0];
      else              flag_nxt = {flag_q[FLAG_T], flag_q[5:0] & ~bus.h_din[5:0]};
    end
    if (clr_done) flag_nxt[FLAG_T] = 1'b0;
  end

  // Flag register and the power-on marker that holds the parasite in reset
  // until the first clear finishes.
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      flag_q <= '0;
      por_q  <= 1'b1;
    end else begin
      flag_q <= flag_nxt;
      if (clr_done) por_q <= 1'b0;
    end
  end

  // Interrupt sources, registered one cycle behind their inputs.
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      h_irq_q <= 1'b1;
      p_irq_q <= 1'b1;
      p_nmi_q <= 1'b1;
    end else begin
      h_irq_q <= ~(flag_q[FLAG_Q] & ph_avail[CH_R4]);
      p_irq_q <= ~((flag_q[FLAG_I] & hp_avail[CH_R1]) | (flag_q[FLAG_J] & hp_avail[CH_R4]));
      p_nmi_q <= ~(flag_q[FLAG_M] & r3_ready(hp_r3_level, flag_q[FLAG_V]));
    end
  end

  assign h_irq_b = h_irq_q | fifo_rst;
  assign p_irq_b = p_irq_q | fifo_rst;
  assign p_nmi_b = p_nmi_q | fifo_rst;
  assign p_rst_b = ~(flag_q[FLAG_P] | por_q);
  assign flags   = flag_q;

endmodule
